// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-level I2C bus master turning START/STOP/WRITE/READ commands into open-drain SCL/SDA phases
// Ports: clk_i/rst_i clock and sync active-high reset; cmd_valid_i/cmd_ready_o/cmd_i/wr_data_i/rd_nack_i command handshake;
//        done_o/ack_o/err_o/rd_data_o completion results; busy_o bus owned; scl_i/sda_i resolved bus levels;
//        scl_o/sda_o 0 = pull low, 1 = release.
// Option: define I2C_CLK_STRETCH_EN to let a slave stretch SCL during q1 of any phase.
module i2c_master_ctrl #(
    parameter int CLK_DIV    = 125,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_nack_i,
    output logic                  done_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  busy_o,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_o,
    output logic                  sda_o
);
    localparam int QW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(DATA_WIDTH - 1);
    typedef enum logic [2:0] {IDLE, START, STOP, BIT, ACK, DONE} state_t;
    state_t state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0] ph_q, ph_d, cmd_q, cmd_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, rd_data_q, rd_data_d;
    logic nack_q, nack_d, rej_q, rej_d, acks_q, acks_d, scl_q, scl_d, sda_q, sda_d;
    logic ready_q, ready_d, done_q, done_d, ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic q_end, stall, on_bus, scl_hi;
`ifdef I2C_CLK_STRETCH_EN
    // a slave holding SCL low while we release it freezes q1 at its first count
    assign stall = (ph_q == 2'd1) && scl_q && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall = 1'b0;
`endif
    assign q_end  = qcnt_q == QMAX;
    assign on_bus = state_q inside {START, STOP, BIT, ACK};
    assign scl_hi = ph_d == 2'd1 || ph_d == 2'd2;
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        ph_d      = ph_q;
        cmd_d     = cmd_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        rd_data_d = rd_data_q;
        nack_d    = nack_q;
        rej_d     = rej_q;
        acks_d    = acks_q;
        ack_d     = ack_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        scl_d     = scl_q;
        sda_d     = sda_q;
        if (state_q == IDLE && cmd_valid_i && ready_q) begin
            cmd_d   = cmd_i;
            nack_d  = rd_nack_i;
            sh_d    = wr_data_i;
            qcnt_d  = '0;
            ph_d    = '0;
            bit_d   = '0;
            rej_d   = cmd_i != 2'd0 && !busy_q;
            busy_d  = busy_q || cmd_i == 2'd0;
            state_d = rej_d ? DONE : cmd_i == 2'd0 ? START : cmd_i == 2'd1 ? STOP : BIT;
        end else if (on_bus) begin
            qcnt_d = (stall || q_end) ? '0 : qcnt_q + 1'b1;
            ph_d   = q_end ? ph_q + 2'd1 : ph_q;
            if (q_end && ph_q == 2'd2) begin
                if (state_q == BIT && cmd_q == 2'd3) sh_d = {sh_q[DATA_WIDTH-2:0], sda_i};
                if (state_q == ACK) acks_d = !sda_i;
            end
            if (q_end && ph_q == 2'd3) begin
                if (state_q == BIT) begin
                    bit_d   = bit_q + 1'b1;
                    sh_d    = cmd_q == 2'd2 ? {sh_q[DATA_WIDTH-2:0], 1'b0} : sh_d;
                    state_d = bit_q == BMAX ? ACK : BIT;
                end else begin
                    state_d = DONE;
                end
            end
        end else if (state_q == DONE) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            err_d     = rej_q;
            ack_d     = !rej_q && cmd_q == 2'd2 && acks_q;
            rd_data_d = (!rej_q && cmd_q == 2'd3) ? sh_q : rd_data_q;
            busy_d    = (!rej_q && cmd_q == 2'd1) ? 1'b0 : busy_q;
        end
        // bus levels are registered from the next phase so they change on a quarter's first cycle;
        // IDLE and DONE hold whatever the last phase left on the bus
        if (state_d == START) begin
            scl_d = scl_hi;
            sda_d = !ph_d[1];
        end else if (state_d == STOP) begin
            scl_d = ph_d != 2'd0;
            sda_d = ph_d[1];
        end else if (state_d == BIT) begin
            scl_d = scl_hi;
            sda_d = cmd_d == 2'd3 || sh_d[DATA_WIDTH-1];
        end else if (state_d == ACK) begin
            scl_d = scl_hi;
            sda_d = cmd_d == 2'd3 ? nack_d : 1'b1;
        end
        // low from the acceptance edge until the cycle after the done pulse
        ready_d = state_d == IDLE && state_q == IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            ph_q      <= '0;
            cmd_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            rd_data_q <= '0;
            nack_q    <= 1'b0;
            rej_q     <= 1'b0;
            acks_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            ph_q      <= ph_d;
            cmd_q     <= cmd_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            rd_data_q <= rd_data_d;
            nack_q    <= nack_d;
            rej_q     <= rej_d;
            acks_q    <= acks_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
        end
    end
    assign cmd_ready_o = ready_q;
    assign done_o      = done_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = busy_q;
    assign scl_o       = scl_q;
    assign sda_o       = sda_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: self-checking bench for i2c_master_ctrl with a behavioural bus responder
module tb_i2c_master_ctrl;
    localparam int CD = 2;
    localparam int LB = 4 * CD + 1;
    localparam int LX = 4 * CD * 9 + 1;
    logic clk = 0, rst = 1, cmd_valid = 0, rd_nack = 0;
    logic [1:0] cmd = 0;
    logic [7:0] wr_data = 0, rd_data;
    logic cmd_ready, done, ack, err, busy, scl_o, sda_o, scl_i, sda_i;
    i2c_master_ctrl #(.CLK_DIV(CD), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_i(cmd),
        .wr_data_i(wr_data), .rd_nack_i(rd_nack), .done_o(done), .ack_o(ack), .err_o(err),
        .rd_data_o(rd_data), .busy_o(busy), .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o)
    );
    always #5 clk = ~clk;
    // responder: selected by a START condition, answers the command latched at acceptance
    int idx = 0, starts = 0, stops = 0, tog = 0, checks = 0, errs = 0;
    logic sel = 0, scl_p = 1, sda_p = 1, a_ae = 0, s_ae = 0;
    logic [1:0] a_cmd = 0;
    logic [7:0] a_tx = 0, s_tx = 0;
    logic [8:0] cap = 0;
    logic slave_low, hold;
    assign slave_low = sel && ((a_cmd == 2'd3 && idx < 8 && !a_tx[3'(7 - idx)]) || (a_cmd == 2'd2 && a_ae && idx == 8));
`ifdef I2C_CLK_STRETCH_EN
    logic stretch_en = 0;
    int st_cnt = 0;
    assign hold = stretch_en && idx == 3 && st_cnt < 50;
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) st_cnt <= 0;
        else if (hold && scl_o) st_cnt <= st_cnt + 1;
    end
`else
    assign hold = 1'b0;
`endif
    assign scl_i = scl_o & ~hold;
    assign sda_i = sda_o & ~slave_low;
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            idx <= 0; cap <= '0; a_cmd <= cmd; a_ae <= s_ae; a_tx <= s_tx;
        end else if (scl_p && !scl_o) idx <= idx + 1;
        if (!scl_p && scl_o) cap <= {cap[7:0], sda_i};
        if (scl_p && scl_o && sda_p && !sda_i) begin starts <= starts + 1; sel <= 1; end
        if (scl_p && scl_o && !sda_p && sda_i) begin stops <= stops + 1; sel <= 0; end
        if (scl_p != scl_o || sda_p != sda_i) tog <= tog + 1;
        scl_p <= scl_o;
        sda_p <= sda_i;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic nk, input logic ae, input logic [7:0] tx);
        int t = 0;
        while (!cmd_ready && t < 500) begin @(posedge clk); #1; t++; end
        if (t >= 500) chk("ready_timeout", 0, 1);
        s_ae = ae; s_tx = tx; cmd = c; wr_data = d; rd_nack = nk; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        chk("ready_fall", cmd_ready, 0);
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!done && lat < 2000);
    endtask
    task automatic run_cmd(input string nm, input logic [1:0] c, input logic [7:0] d, input logic nk, input logic ae,
                           input logic [7:0] tx, input logic e_err, input logic e_ack, input logic [7:0] e_rd,
                           input logic e_busy, input int e_lat);
        int s0 = starts, p0 = stops, t0 = tog, lat;
        issue(c, d, nk, ae, tx);
        wait_done(lat);
        chk({nm, "_lat"}, lat, e_lat);
        chk({nm, "_err"}, err, e_err);
        chk({nm, "_ack"}, ack, e_ack);
        chk({nm, "_rd"}, rd_data, e_rd);
        chk({nm, "_busy"}, busy, e_busy);
        if (e_err) chk({nm, "_quiet"}, tog, t0);
        else if (c == 2'd0) chk({nm, "_startcond"}, starts, s0 + 1);
        else if (c == 2'd1) chk({nm, "_stopcond"}, stops, p0 + 1);
        else if (c == 2'd2) chk({nm, "_wrbyte"}, cap[8:1], d);
        else chk({nm, "_9th"}, cap[0], nk);
        @(posedge clk); #1;
        chk({nm, "_pulse"}, done, 0);
        chk({nm, "_readyback"}, cmd_ready, 1);
    endtask
    typedef struct {
        logic [1:0] c; logic [7:0] d; logic nk; logic ae; logic [7:0] tx;
        logic e_err; logic e_ack; logic [7:0] e_rd; logic e_busy; int e_lat;
    } vec_t;
    function automatic vec_t mk(logic [1:0] c, logic [7:0] d, logic nk, logic ae, logic [7:0] tx,
                                logic e_err, logic e_ack, logic [7:0] e_rd, logic e_busy, int e_lat);
        vec_t v;
        v.c = c; v.d = d; v.nk = nk; v.ae = ae; v.tx = tx;
        v.e_err = e_err; v.e_ack = e_ack; v.e_rd = e_rd; v.e_busy = e_busy; v.e_lat = e_lat;
        return v;
    endfunction
    vec_t tbl[23];
    initial begin
        logic bm;
        logic [7:0] rm;
        int t;
        tbl[0]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1, LB);
        tbl[1]  = mk(2, 8'h44, 0, 1, 8'h00, 0, 1, 8'h00, 1, LX);
        tbl[2]  = mk(2, 8'h5A, 0, 1, 8'h00, 0, 1, 8'h00, 1, LX);
        tbl[3]  = mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, LB);
        tbl[4]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1, LB);
        tbl[5]  = mk(2, 8'h45, 0, 1, 8'h00, 0, 1, 8'h00, 1, LX);
        tbl[6]  = mk(3, 8'h00, 1, 0, 8'd100, 0, 0, 8'd100, 1, LX);
        tbl[7]  = mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 8'd100, 0, LB);
        tbl[8]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'd100, 1, LB);
        tbl[9]  = mk(2, 8'h45, 0, 1, 8'h00, 0, 1, 8'd100, 1, LX);
        tbl[10] = mk(3, 8'h00, 1, 0, 8'd101, 0, 0, 8'd101, 1, LX);
        tbl[11] = mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 8'd101, 0, LB);
        tbl[12] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'd101, 1, LB);
        tbl[13] = mk(2, 8'h30, 0, 0, 8'h00, 0, 0, 8'd101, 1, LX);
        tbl[14] = mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 8'd101, 0, LB);
        tbl[15] = mk(2, 8'h12, 0, 1, 8'h00, 1, 0, 8'd101, 0, 1);
        tbl[16] = mk(3, 8'h00, 0, 0, 8'hFF, 1, 0, 8'd101, 0, 1);
        tbl[17] = mk(1, 8'h00, 0, 0, 8'h00, 1, 0, 8'd101, 0, 1);
        tbl[18] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'd101, 1, LB);
        tbl[19] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'd101, 1, LB);
        tbl[20] = mk(3, 8'h00, 0, 0, 8'hA5, 0, 0, 8'hA5, 1, LX);
        tbl[21] = mk(2, 8'h3C, 0, 1, 8'h00, 0, 1, 8'hA5, 1, LX);
        tbl[22] = mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 8'hA5, 0, LB);
        cmd_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        cmd_valid = 0;
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("idle%0d_scl", i), scl_o, 1);
            chk($sformatf("idle%0d_sda", i), sda_o, 1);
            chk($sformatf("idle%0d_ready", i), cmd_ready, 1);
            chk($sformatf("idle%0d_done", i), done, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 23; i++)
            run_cmd($sformatf("v%0d", i), tbl[i].c, tbl[i].d, tbl[i].nk, tbl[i].ae, tbl[i].tx,
                    tbl[i].e_err, tbl[i].e_ack, tbl[i].e_rd, tbl[i].e_busy, tbl[i].e_lat);
        bm = 0;
        rm = 8'hA5;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] c;
            logic [7:0] d, tx;
            logic nk, ae, e_err;
            c = 2'($urandom_range(0, 3)); d = 8'($urandom); tx = 8'($urandom);
            nk = 1'($urandom); ae = 1'($urandom);
            e_err = c != 2'd0 && !bm;
            if (!e_err && c == 2'd3) rm = tx;
            if (!e_err) bm = c == 2'd0 ? 1'b1 : c == 2'd1 ? 1'b0 : bm;
            run_cmd($sformatf("r%0d", i), c, d, nk, ae, tx, e_err, !e_err && c == 2'd2 && ae, rm, bm,
                    e_err ? 1 : c < 2'd2 ? LB : LX);
        end
        if (bm) run_cmd("rclose", 1, 0, 0, 0, 0, 0, 0, rm, 0, LB);
        run_cmd("mr_start", 0, 0, 0, 0, 0, 0, 0, rm, 1, LB);
        issue(2, 8'hC3, 0, 1, 0);
        t = 0;
        while (idx != 4 && t < 500) begin @(posedge clk); #1; t++; end
        chk("mr_reach_bit4", idx, 4);
        rst = 1;
        @(posedge clk); #1;
        chk("mr_scl", scl_o, 1);
        chk("mr_sda", sda_o, 1);
        chk("mr_busy", busy, 0);
        chk("mr_ready", cmd_ready, 1);
        chk("mr_done", done, 0);
        rst = 0;
        run_cmd("pr_start", 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, LB);
        run_cmd("pr_wr", 2, 8'h81, 0, 1, 0, 0, 1, 8'h00, 1, LX);
        run_cmd("pr_stop", 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, LB);
`ifdef I2C_CLK_STRETCH_EN
        run_cmd("st_start", 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, LB);
        stretch_en = 1;
        run_cmd("st_wr", 2, 8'h5A, 0, 1, 0, 0, 1, 8'h00, 1, LX + 50);
        stretch_en = 0;
        run_cmd("st_stop", 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, LB);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Synthesizable I2C bus initiator: the master end of the two-wire bus that the `i2c_if` slave BFM responds to. It takes byte-level commands (START, STOP, WRITE, READ) over a valid/ready handshake and generates open-drain SCL/SDA waveforms. It returns the ACK status for writes and the received byte for reads. It sits between the register/command front end and the bus pads; one instance drives one bus.

## Interface
Parameters:
- `CLK_DIV`, default 125: clk cycles per quarter bit period; must be ≥ 2. The SCL period is 4·CLK_DIV cycles.
- `DATA_WIDTH`, default 8: bits per byte transfer.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `cmd_valid_i`  in  1  command request.
- `cmd_ready_o`  out  1  controller can accept a command.
- `cmd_i`  in  2  0=START, 1=STOP, 2=WRITE, 3=READ.
- `wr_data_i`  in  DATA_WIDTH  byte for WRITE; sampled at acceptance.
- `rd_nack_i`  in  1  READ only: 1 = master sends NACK on the 9th bit, 0 = ACK; sampled at acceptance.
- `done_o`  out  1  one-cycle pulse at command completion.
- `ack_o`  out  1  WRITE: 1 if the slave drove SDA low on the 9th bit; valid with `done_o`.
- `err_o`  out  1  command rejected; valid with `done_o`.
- `rd_data_o`  out  DATA_WIDTH  READ result; held until the next READ completes.
- `busy_o`  out  1  bus owned (after START, before STOP completes).
- `scl_i`, `sda_i`  in  1  resolved bus levels.
- `scl_o`, `sda_o`  out  1  0 = pull low, 1 = release.

## Operation
- States: IDLE, START, STOP, BIT, ACK, DONE.
- A command is accepted on a cycle where `cmd_valid_i && cmd_ready_o`. `cmd_ready_o` is high only in IDLE. Acceptance moves the block to START, STOP, or BIT.
- Each bus phase is four quarters of CLK_DIV cycles. A quarter counter counts 0..CLK_DIV-1; a phase counter counts q0..q3.
- START (used for both first and repeated START):
  - q0: scl=0, sda=1.
  - q1: scl=1, sda=1.
  - q2: scl=1, sda=0.
  - q3: scl=0, sda=0.
  - Sets `busy_o`.
- STOP:
  - q0: scl=0, sda=0.
  - q1: scl=1, sda=0.
  - q2: scl=1, sda=1.
  - q3: scl=1, sda=1.
  - Clears `busy_o` at completion.
- BIT: DATA_WIDTH bits, MSB first.
  - q0: scl=0 with sda set up.
  - q1 and q2: scl=1.
  - q3: scl=0.
  - WRITE drives the data bit. READ releases sda and shifts in `sda_i` on the last cycle of q2.
- ACK (9th bit), same four quarters:
  - WRITE releases sda and samples `sda_i` on the last cycle of q2; `ack_o = ~sda_i`.
  - READ drives `sda_o = rd_nack_i`.
- DONE: `done_o` is pulsed for one cycle, `rd_data_o`, `ack_o`, and `err_o` are updated, then the block returns to IDLE.
- Error cases: WRITE, READ, or STOP issued while `busy_o`=0 is not executed. The block goes directly to DONE with `err_o`=1, and the bus is untouched.
- START while `busy_o`=1 is legal and produces a repeated START.
- Reset mid-operation: all state returns to reset values on the next edge, and SCL/SDA are released immediately. The bus may be left mid-byte; no STOP is generated.
- Bit counter widths: $clog2(DATA_WIDTH+1) bits and $clog2(CLK_DIV) bits. Neither counter wraps past its terminal count.

## Timing
- Reset values: `scl_o`=1, `sda_o`=1, `cmd_ready_o`=1, `done_o`=0, `ack_o`=0, `err_o`=0, `rd_data_o`=0, `busy_o`=0, state IDLE.
- Outputs are registered. `scl_o`/`sda_o` change on the first cycle of each quarter.
- Latency from the acceptance edge to `done_o`:
  - START or STOP: 4·CLK_DIV+1 cycles.
  - WRITE or READ: 4·CLK_DIV·(DATA_WIDTH+1)+1 cycles.
  - Rejected command: 1 cycle.
- `cmd_ready_o` falls the cycle after acceptance and rises the cycle after `done_o`. A back-to-back command can therefore be accepted 1 cycle after `done_o`.
- `cmd_valid_i` asserted during reset is ignored.

## Configuration
- `I2C_CLK_STRETCH_EN`:
  - Defined: in q1 of every phase, the quarter counter holds at 0 while `scl_o`=1 and `scl_i`=0. A slave can stretch SCL this way; latency grows by the stretch length.
  - Undefined: `scl_i` is ignored and timing is exactly as stated above.

## Test plan
- Reset, then idle 20 cycles -> `scl_o`=`sda_o`=1, `cmd_ready_o`=1, `done_o` never pulses.
- CLK_DIV=2, against an `i2c_if` slave BFM with MY_ADDRESS=0x22:
  - START, then WRITE 0x44 (address 0x22 + write) -> SDA falls while SCL is high. WRITE `done_o` arrives 73 cycles after acceptance with `ack_o`=1. Then WRITE 0x5A (slave records 0x5A) and STOP -> `busy_o`=0 and SDA rises while SCL is high.
  - START, WRITE 0x45, then READ with `rd_nack_i`=1 -> `rd_data_o`=100 (first BFM read value) and the 9th bit has SDA=1. A second transaction returns 101.
  - WRITE to an unmatched address with no responder -> `ack_o`=0, `err_o`=0. Then STOP completes normally.
- From reset, issue WRITE 0x12 with no START -> `done_o` 1 cycle later with `err_o`=1. SCL/SDA never toggle.
- Assert `rst_i` at bit 4 of a WRITE -> next cycle `scl_o`=`sda_o`=1, `busy_o`=0, `cmd_ready_o`=1.
- With `I2C_CLK_STRETCH_EN`: hold `scl_i` low for 50 cycles during bit 3 of a WRITE -> `done_o` latency is 73+50 cycles and the byte is received intact.
